// File: rtl/vmul_seq_ctrl.sv
// vmul_seq_ctrl: sequences a multi-word vector multiply through an external
// multiplier, one 32-bit word at a time. For each word it issues the operands,
// waits for the product and writes it back. It reports completion (with an
// error flag) once the last word has been written back.
// Optional feature: define VMUL_SEQ_TIMEOUT_EN to bound the wait for mul_done
// to TMO_CYCLES cycles. On expiry the request completes with cpl_err=1.
module vmul_seq_ctrl #(
    parameter int MAX_WORDS  = 16,
    parameter int TMO_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [2:0]                    req_sew,
    input  logic [$clog2(MAX_WORDS):0]    req_nwords,
    output logic [$clog2(MAX_WORDS)-1:0]  op_idx,
    input  logic [31:0]                   op_a,
    input  logic [31:0]                   op_b,
    output logic                          mul_start,
    output logic [2:0]                    mul_sew,
    output logic                          mul_mode_32bit,
    output logic [31:0]                   mul_a,
    output logic [31:0]                   mul_b,
    input  logic                          mul_done,
    input  logic [31:0]                   mul_product_1,
    input  logic [31:0]                   mul_product_2,
    output logic                          wb_valid,
    output logic [$clog2(MAX_WORDS)-1:0]  wb_idx,
    output logic [31:0]                   wb_lo,
    output logic [31:0]                   wb_hi,
    output logic                          cpl_valid,
    output logic                          cpl_err,
    input  logic                          flush,
    output logic                          busy
);

    localparam int IW = $clog2(MAX_WORDS);
    localparam int NW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_CPL
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [NW-1:0]   nwords_q;
    logic            err_q;

    logic            sew_legal;
    logic [NW-1:0]   nwords_sat;
    logic            more_words;

    assign sew_legal  = (req_sew == 3'b000) || (req_sew == 3'b001) || (req_sew == 3'b010);
    assign nwords_sat = (req_nwords > NW'(MAX_WORDS)) ? NW'(MAX_WORDS) : req_nwords;
    // Only evaluated in WB, where nwords_q is at least 1, so the subtraction cannot wrap.
    assign more_words = ({1'b0, idx} < (nwords_q - NW'(1)));

`ifdef VMUL_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES) + 1;
    logic [TW-1:0]   wait_cnt;
    logic            tmo_hit;
    assign tmo_hit = (wait_cnt == TW'(TMO_CYCLES - 1));
`endif

    // req_ready must react to flush in the same cycle, so it stays combinational.
    assign req_ready = (state == S_IDLE) && !flush;
    assign busy      = (state != S_IDLE);
    assign op_idx    = idx;
    assign wb_idx    = idx;

    // Sequencer FSM. All pulse outputs are registered. mul_start and the
    // operands appear together in the first WAIT cycle. wb_valid covers the
    // WB cycle, and cpl_valid follows the CPL cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            idx            <= '0;
            nwords_q       <= '0;
            err_q          <= 1'b0;
            mul_start      <= 1'b0;
            mul_sew        <= 3'b000;
            mul_mode_32bit <= 1'b0;
            mul_a          <= '0;
            mul_b          <= '0;
            wb_valid       <= 1'b0;
            wb_lo          <= '0;
            wb_hi          <= '0;
            cpl_valid      <= 1'b0;
            cpl_err        <= 1'b0;
`ifdef VMUL_SEQ_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            mul_start <= 1'b0;
            wb_valid  <= 1'b0;
            cpl_valid <= 1'b0;
            cpl_err   <= 1'b0;
            if (flush) begin
                // Abort wins over everything, including a same-cycle mul_done.
                // A wb_valid already showing this cycle has been issued.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req_valid) begin
                            mul_sew        <= req_sew;
                            mul_mode_32bit <= (req_sew == 3'b010);
                            nwords_q       <= nwords_sat;
                            idx            <= '0;
                            err_q          <= !sew_legal;
                            state          <= (sew_legal && (req_nwords != '0)) ? S_ISSUE : S_CPL;
                        end
                    end
                    S_ISSUE: begin
                        mul_a     <= op_a;
                        mul_b     <= op_b;
                        mul_start <= 1'b1;
                        state     <= S_WAIT;
`ifdef VMUL_SEQ_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end
                    S_WAIT: begin
                        if (mul_done) begin
                            wb_lo    <= mul_product_1;
                            wb_hi    <= mul_product_2;
                            wb_valid <= 1'b1;
                            state    <= S_WB;
                        end
`ifdef VMUL_SEQ_TIMEOUT_EN
                        else if (tmo_hit) begin
                            // Give up on this word and skip the rest of the request.
                            err_q <= 1'b1;
                            state <= S_CPL;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
`endif
                    end
                    S_WB: begin
                        if (more_words) begin
                            idx   <= idx + IW'(1);
                            state <= S_ISSUE;
                        end else begin
                            state <= S_CPL;
                        end
                    end
                    S_CPL: begin
                        cpl_valid <= 1'b1;
                        cpl_err   <= err_q;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vmul_seq_ctrl.sv
// Self-checking bench for vmul_seq_ctrl. It contains a multiplier model that
// answers L cycles after mul_start. Each request is compared with an
// expectation built from the request rules: the number of words, the products,
// the error flag, and a per-word cost of L+3 cycles.
module tb_vmul_seq_ctrl;

    localparam int MAXW = 16;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sew;
    logic [4:0]  req_nwords;
    logic [3:0]  op_idx;
    logic [31:0] op_a, op_b;
    logic        mul_start;
    logic [2:0]  mul_sew;
    logic        mul_mode_32bit;
    logic [31:0] mul_a, mul_b;
    logic        mul_done;
    logic [31:0] mul_product_1, mul_product_2;
    logic        wb_valid;
    logic [3:0]  wb_idx;
    logic [31:0] wb_lo, wb_hi;
    logic        cpl_valid;
    logic        cpl_err;
    logic        flush;
    logic        busy;

    always #5 clk = ~clk;

    vmul_seq_ctrl #(.MAX_WORDS(MAXW), .TMO_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sew(req_sew), .req_nwords(req_nwords),
        .op_idx(op_idx), .op_a(op_a), .op_b(op_b),
        .mul_start(mul_start), .mul_sew(mul_sew), .mul_mode_32bit(mul_mode_32bit),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_product_1(mul_product_1), .mul_product_2(mul_product_2),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_lo(wb_lo), .wb_hi(wb_hi),
        .cpl_valid(cpl_valid), .cpl_err(cpl_err),
        .flush(flush), .busy(busy)
    );

    // Operand buffers, read combinationally at op_idx.
    logic [31:0] opa [MAXW];
    logic [31:0] opb [MAXW];
    assign op_a = opa[op_idx];
    assign op_b = opb[op_idx];

    int n_checks = 0;
    int n_fail   = 0;

    // Observation and multiplier-model state.
    int          cyc, n_start, n_wb, n_cpl, cpl_cyc;
    logic        last_err;
    int          wbq_idx [$];
    logic [31:0] wbq_lo [$];
    logic [31:0] wbq_hi [$];
    int          pend, lat;
    logic [63:0] prod;
    logic        mdl_en, spur;

    function automatic logic [63:0] ref_prod(int i);
        return {32'h0, opa[i]} * {32'h0, opb[i]};
    endfunction

    // One clock. Sample the outputs just after the edge, then drive the
    // multiplier response for the cycle that has just begun.
    task automatic tick();
        logic done_now;
        @(posedge clk);
        #1;
        cyc++;
        done_now = 1'b0;
        if (mul_start) begin
            n_start++;
            prod = {32'h0, mul_a} * {32'h0, mul_b};
            pend = lat;
        end else if (pend > 0) begin
            pend--;
            done_now = (pend == 0);
        end
        if (wb_valid) begin
            n_wb++;
            wbq_idx.push_back(int'(wb_idx));
            wbq_lo.push_back(wb_lo);
            wbq_hi.push_back(wb_hi);
        end
        if (cpl_valid) begin
            n_cpl++;
            cpl_cyc  = cyc;
            last_err = cpl_err;
        end
        mul_done      = spur | (mdl_en & done_now);
        mul_product_1 = prod[31:0];
        mul_product_2 = prod[63:32];
    endtask

    // Offer a request for one cycle. The cycle after acceptance is cyc=1.
    task automatic start_req(input logic [2:0] sew, input int nw);
        n_start = 0; n_wb = 0; n_cpl = 0; cpl_cyc = -1; last_err = 1'bx; pend = 0;
        wbq_idx.delete(); wbq_lo.delete(); wbq_hi.delete();
        req_sew    = sew;
        req_nwords = 5'(nw);
        req_valid  = 1'b1;
        cyc        = 0;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic run_to_cpl(input int maxc);
        while (n_cpl == 0 && cyc < maxc) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b1;
        req_sew = 3'b010;
        req_nwords = 5'd3;
        flush = 1'($urandom_range(0, 1));
        repeat (3) tick();
        n_checks++;
        if ({busy, mul_start, wb_valid, cpl_valid, cpl_err, mul_mode_32bit} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got busy/start/wb/cpl/err/mode=%b want 000000",
                     {busy, mul_start, wb_valid, cpl_valid, cpl_err, mul_mode_32bit});
        end
        n_checks++;
        if ({mul_a, mul_b, wb_lo, wb_hi, mul_sew, op_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_data got a=%h b=%h lo=%h hi=%h sew=%b idx=%0d want all zero",
                     mul_a, mul_b, wb_lo, wb_hi, mul_sew, op_idx);
        end
        reset = 1'b0;
        req_valid = 1'b0;
        flush = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_basic();
        opa[0] = 32'h00040003; opb[0] = 32'h00080007;
        opa[1] = 32'h00020001; opb[1] = 32'h00060005;
        lat = 4;
        start_req(3'b010, 2);
        run_to_cpl(100);
        repeat (2) tick();
        n_checks++;
        if (n_start !== 2 || mul_mode_32bit !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start got starts=%0d mode=%b want 2 1", n_start, mul_mode_32bit);
        end
        n_checks++;
        if (n_wb !== 2) begin
            n_fail++;
            $display("FAIL basic_wbcount got %0d want 2", n_wb);
        end
        for (int i = 0; i < 2 && i < wbq_idx.size(); i++) begin
            n_checks++;
            if (wbq_idx[i] !== i || {wbq_hi[i], wbq_lo[i]} !== ref_prod(i)) begin
                n_fail++;
                $display("FAIL basic_wb%0d got idx=%0d hi:lo=%h:%h want idx=%0d %h",
                         i, wbq_idx[i], wbq_hi[i], wbq_lo[i], i, ref_prod(i));
            end
        end
        n_checks++;
        if (n_cpl !== 1 || last_err !== 1'b0 || cpl_cyc !== 2 * (4 + 3) + 2) begin
            n_fail++;
            $display("FAIL basic_cpl got n=%0d err=%b cyc=%0d want 1 0 %0d",
                     n_cpl, last_err, cpl_cyc, 2 * 7 + 2);
        end
    endtask

    task automatic test_noop();
        lat = 3;
        start_req(3'($urandom_range(0, 2)), 0);
        run_to_cpl(20);
        tick();
        n_checks++;
        if (n_start !== 0 || n_wb !== 0) begin
            n_fail++;
            $display("FAIL noop_activity got starts=%0d wbs=%0d want 0 0", n_start, n_wb);
        end
        n_checks++;
        if (n_cpl !== 1 || cpl_cyc !== 2 || last_err !== 1'b0) begin
            n_fail++;
            $display("FAIL noop_cpl got n=%0d cyc=%0d err=%b want 1 2 0", n_cpl, cpl_cyc, last_err);
        end
    endtask

    task automatic test_illegal();
        lat = 3;
        start_req(3'b111, 4);
        run_to_cpl(40);
        tick();
        n_checks++;
        if (n_start !== 0 || n_wb !== 0) begin
            n_fail++;
            $display("FAIL illegal_activity got starts=%0d wbs=%0d want 0 0", n_start, n_wb);
        end
        n_checks++;
        if (n_cpl !== 1 || last_err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_cpl got n=%0d err=%b want 1 1", n_cpl, last_err);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            logic [2:0] sew;
            int nw, n;
            logic legal;
            sew = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) sew = 3'($urandom_range(0, 2));
            nw  = $urandom_range(0, 31);
            lat = $urandom_range(1, 5);
            for (int i = 0; i < MAXW; i++) begin
                opa[i] = $urandom;
                opb[i] = $urandom;
            end
            legal = (sew <= 3'd2);
            n = legal ? ((nw > MAXW) ? MAXW : nw) : 0;
            start_req(sew, nw);
            run_to_cpl(n * (lat + 3) + 20);
            repeat (2) tick();
            n_checks++;
            if (n_cpl !== 1 || last_err !== !legal || cpl_cyc !== n * (lat + 3) + 2) begin
                n_fail++;
                $display("FAIL rand%0d_cpl sew=%b nw=%0d lat=%0d got n=%0d err=%b cyc=%0d want 1 %b %0d",
                         it, sew, nw, lat, n_cpl, last_err, cpl_cyc, !legal, n * (lat + 3) + 2);
            end
            n_checks++;
            if (n_start !== n || n_wb !== n) begin
                n_fail++;
                $display("FAIL rand%0d_count got starts=%0d wbs=%0d want %0d", it, n_start, n_wb, n);
            end
            n_checks++;
            if (mul_sew !== sew || mul_mode_32bit !== (sew == 3'b010)) begin
                n_fail++;
                $display("FAIL rand%0d_sew got sew=%b mode=%b want %b %b",
                         it, mul_sew, mul_mode_32bit, sew, sew == 3'b010);
            end
            for (int i = 0; i < n && i < wbq_idx.size(); i++) begin
                n_checks++;
                if (wbq_idx[i] !== i || {wbq_hi[i], wbq_lo[i]} !== ref_prod(i)) begin
                    n_fail++;
                    $display("FAIL rand%0d_wb%0d got idx=%0d hi:lo=%h:%h want idx=%0d %h",
                             it, i, wbq_idx[i], wbq_hi[i], wbq_lo[i], i, ref_prod(i));
                end
            end
        end
    endtask

    task automatic test_flush_wait();
        lat = 10;
        start_req(3'b001, 3);
        while (n_start < 2 && cyc < 60) tick();
        n_checks++;
        if (n_start !== 2) begin
            n_fail++;
            $display("FAIL flushwait_reach got starts=%0d want 2", n_start);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flushwait_ready got ready=%b busy=%b want 1 0", req_ready, busy);
        end
        repeat (40) tick();
        n_checks++;
        if (n_start !== 2 || n_wb !== 1 || n_cpl !== 0) begin
            n_fail++;
            $display("FAIL flushwait_after got starts=%0d wbs=%0d cpls=%0d want 2 1 0", n_start, n_wb, n_cpl);
        end
    endtask

    task automatic test_flush_wb();
        lat = 2;
        start_req(3'b000, 2);
        while (n_wb < 1 && cyc < 40) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (30) tick();
        n_checks++;
        if (n_wb !== 1 || n_start !== 1 || n_cpl !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flushwb got wbs=%0d starts=%0d cpls=%0d busy=%b want 1 1 0 0",
                     n_wb, n_start, n_cpl, busy);
        end
    endtask

    task automatic test_flush_vs_done();
        lat = 3;
        start_req(3'b010, 1);
        while (mul_done !== 1'b1 && cyc < 40) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (n_wb !== 0 || n_cpl !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flushdone got wbs=%0d cpls=%0d busy=%b want 0 0 0", n_wb, n_cpl, busy);
        end
    endtask

    task automatic test_spurious_done();
        int wb0;
        wb0 = n_wb;
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (n_wb !== wb0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_idle got wbs=%0d busy=%b want %0d 0", n_wb, busy, wb0);
        end
        lat = 5;
        spur = 1'b1;
        start_req(3'b010, 1);
        spur = 1'b0;
        run_to_cpl(60);
        tick();
        n_checks++;
        if (n_wb !== 1 || n_start !== 1 || cpl_cyc !== 1 * (5 + 3) + 2) begin
            n_fail++;
            $display("FAIL spur_issue got wbs=%0d starts=%0d cyc=%0d want 1 1 %0d", n_wb, n_start, cpl_cyc, 10);
        end
    endtask

    task automatic test_no_done();
        mdl_en = 1'b0;
        lat = 1;
        start_req(3'b010, 2);
`ifdef VMUL_SEQ_TIMEOUT_EN
        run_to_cpl(TMO + 20);
        tick();
        n_checks++;
        if (n_cpl !== 1 || last_err !== 1'b1 || cpl_cyc !== TMO + 3 || n_wb !== 0 || n_start !== 1) begin
            n_fail++;
            $display("FAIL timeout got n=%0d err=%b cyc=%0d wbs=%0d starts=%0d want 1 1 %0d 0 1",
                     n_cpl, last_err, cpl_cyc, n_wb, n_start, TMO + 3);
        end
`else
        repeat (TMO + 50) tick();
        n_checks++;
        if (busy !== 1'b1 || n_cpl !== 0 || n_wb !== 0) begin
            n_fail++;
            $display("FAIL nodone_hang got busy=%b cpls=%0d wbs=%0d want 1 0 0", busy, n_cpl, n_wb);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL nodone_recover got busy=%b ready=%b want 0 1", busy, req_ready);
        end
`endif
        mdl_en = 1'b1;
    endtask

    task automatic test_reset_midop();
        lat = 5;
        start_req(3'b010, 3);
        repeat (4) tick();
        reset = 1'b1;
        flush = 1'b1;
        req_valid = 1'b1;
        tick();
        n_checks++;
        if ({busy, mul_start, wb_valid, cpl_valid, mul_mode_32bit} !== 5'b0 || mul_sew !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_state got busy/start/wb/cpl/mode=%b sew=%b want 00000 000",
                     {busy, mul_start, wb_valid, cpl_valid, mul_mode_32bit}, mul_sew);
        end
        reset = 1'b0;
        flush = 1'b0;
        req_valid = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready got %b want 1", req_ready);
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_sew = 3'b000; req_nwords = '0; flush = 1'b0;
        mul_done = 1'b0; mul_product_1 = '0; mul_product_2 = '0;
        mdl_en = 1'b1; spur = 1'b0; lat = 4; pend = 0; prod = '0; cyc = 0;
        n_start = 0; n_wb = 0; n_cpl = 0; cpl_cyc = -1; last_err = 1'b0;
        for (int i = 0; i < MAXW; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom;
        end
        test_reset();
        test_basic();
        test_noop();
        test_illegal();
        test_random();
        test_flush_wait();
        test_flush_wb();
        test_flush_vs_done();
        test_spurious_done();
        test_no_done();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vmul_seq_ctrl.md
VMUL_SEQ_CTRL -- requirements
Module: vmul_seq_ctrl

Interface
REQ-001 Parameter MAX_WORDS, default 16; maximum 32-bit words per request.
REQ-002 Parameter TMO_CYCLES, default 64; done-timeout limit, used only when VMUL_SEQ_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 req_valid  in  1  request offered.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 req_sew  in  3  element width: 000=8b, 001=16b, 010=32b, others illegal.
REQ-008 req_nwords  in  $clog2(MAX_WORDS)+1  number of 32-bit words to multiply.
REQ-009 op_idx  out  $clog2(MAX_WORDS)  word index into the operand buffers.
REQ-010 op_a, op_b  in  32 each  operand words at op_idx, combinational read, same cycle.
REQ-011 mul_start  out  1  one-cycle multiplier start pulse.
REQ-012 mul_sew  out  3  latched SEW driven to the multiplier.
REQ-013 mul_mode_32bit  out  1  asserted iff latched SEW is 010.
REQ-014 mul_a, mul_b  out  32 each  operands registered on the mul_start cycle.
REQ-015 mul_done  in  1  multiplier result valid, one-cycle pulse.
REQ-016 mul_product_1, mul_product_2  in  32 each  product low and high words.
REQ-017 wb_valid  out  1  one-cycle result write pulse.
REQ-018 wb_idx  out  $clog2(MAX_WORDS)  word index of the result.
REQ-019 wb_lo, wb_hi  out  32 each  captured product_1 and product_2.
REQ-020 cpl_valid  out  1  one-cycle completion pulse.
REQ-021 cpl_err  out  1  error flag, valid only with cpl_valid.
REQ-022 flush  in  1  synchronous abort.
REQ-023 busy  out  1  high whenever state is not IDLE.

Function
REQ-024 FSM states and transitions:
- IDLE -> ISSUE on req_valid & req_ready, when SEW is legal and nwords is nonzero.
- IDLE -> CPL on accept when nwords is 0 or SEW is illegal.
- ISSUE -> WAIT after one cycle.
- WAIT -> WB on mul_done.
- WB -> ISSUE when the current index is below nwords-1; otherwise WB -> CPL.
- CPL -> IDLE after one cycle.
REQ-025 req_ready is high only in IDLE with flush low; on acceptance sew and nwords are latched and the index is cleared to 0.
REQ-026 ISSUE: mul_start=1 for exactly one cycle; mul_a and mul_b capture op_a and op_b at op_idx on that cycle.
REQ-027 mul_done is sampled only in WAIT; mul_done in any other state is ignored.
REQ-028 On mul_done in WAIT, product_1 and product_2 are captured into wb_lo and wb_hi.
REQ-029 WB: wb_valid=1 for one cycle with wb_idx equal to the current index; the index increments on exit from WB.
REQ-030 Minimum latency per word is 3 cycles plus multiplier latency; the request-to-cpl_valid cycle count is deterministic for a fixed multiplier latency.
REQ-031 nwords greater than MAX_WORDS is saturated to MAX_WORDS.
REQ-032 cpl_err=1 on completion iff SEW was illegal or a timeout occurred.
REQ-033 cpl_err=0 for a nwords=0 no-op.
REQ-034 flush in any state: the next state is IDLE and no cpl_valid is issued.
REQ-035 flush in WB: the wb_valid of that cycle is still issued.
REQ-036 flush has priority over mul_done in the same cycle.
REQ-037 flush held with req_valid in IDLE: the request is not accepted.
REQ-038 mul_sew and mul_mode_32bit hold the latched values until the next acceptance.

Reset
REQ-039 On reset:
- state=IDLE and index=0.
- mul_start, wb_valid, cpl_valid, cpl_err, busy = 0.
- mul_a, mul_b, wb_lo, wb_hi = 0; mul_sew=000; mul_mode_32bit=0.
REQ-040 Reset asserted mid-operation overrides flush and every other input; the first cycle after deassert has req_ready=1.

Configuration
REQ-041 Macro VMUL_SEQ_TIMEOUT_EN defined: a wait counter clears on entry to WAIT.
REQ-042 With VMUL_SEQ_TIMEOUT_EN, after TMO_CYCLES WAIT cycles without mul_done the FSM goes to CPL with cpl_err=1 and the remaining words are skipped.
REQ-043 Macro undefined: no counter exists and WAIT waits indefinitely.

Verification
REQ-044 sew=010, nwords=2, words {0x00040003,0x00020001} and {0x00080007,0x00060005}, 4-cycle multiplier model -> two mul_start pulses, mode_32bit=1, wb_idx 0 then 1, then one cpl_valid with cpl_err=0.
REQ-045 nwords=0 -> no mul_start or wb_valid; cpl_valid exactly 2 cycles after acceptance; cpl_err=0.
REQ-046 sew=111, nwords=4 -> no mul_start; cpl_valid with cpl_err=1.
REQ-047 flush asserted in WAIT of word 1 of 3 -> no further mul_start, no cpl_valid; req_ready=1 the next cycle.
REQ-048 mul_done pulsed in IDLE and in ISSUE -> ignored; no wb_valid.
REQ-049 VMUL_SEQ_TIMEOUT_EN defined, mul_done never asserted -> cpl_valid with cpl_err=1 after 64 WAIT cycles; without the macro, busy stays high.
